tpulse_seq_monitor: RTL and testbench
=====================================

Name: tpulse_seq_monitor

Overview:
- Receiver-side checker for the timer's T01–T12 timepulse ring.
- Samples the 12 timepulses, plus GOJAM and STOP, on SIM_CLK.
- Tracks the expected sequence, counts completed MCTs, and raises sticky error flags when the ring skips, overlaps or stalls.
- Sits alongside a2_timer in simulation and FPGA builds, as the consumer/decoder of its timing outputs.

Parameters:
- CNT_W, 16, width of MCT counter (wraps modulo 2^CNT_W).
- GAP_MAX, 64, max consecutive SIM_CLK cycles with no timepulse high before GAP_ERR.
- WMIN, 8, min pulse width in SIM_CLK cycles (optional feature only).
- WMAX, 40, max pulse width in SIM_CLK cycles (optional feature only).

Ports:
- SIM_CLK  in  1  single clock; all state updates on rising edge.
- SIM_RST  in  1  asynchronous, active-high reset.
- TP  in  12  timepulses; TP[0]=T01 … TP[11]=T12; active-high, synchronous to SIM_CLK.
- GOJAM  in  1  active-high; forces resynchronisation.
- STOP  in  1  active-high; timer halted, gap check suspended.
- CLR  in  1  synchronous clear of flags and counter.
- SYNCED  out  1  high while state = TRACK.
- CUR_T  out  4  index (1–12) of last accepted pulse; 0 when none.
- MCT_COUNT  out  CNT_W  completed T12→T01 transitions while TRACK.
- SEQ_ERR  out  1  sticky; out-of-order pulse seen.
- ONEHOT_ERR  out  1  sticky; more than one TP bit high.
- GAP_ERR  out  1  sticky; no pulse for more than GAP_MAX cycles.
- WIDTH_ERR  out  1  sticky; pulse width out of range (optional feature).
- ERR_EXP  out  4  expected index at first SEQ_ERR.
- ERR_GOT  out  4  received index at first SEQ_ERR.

Behaviour:
- Reset (async): state=IDLE. All outputs 0. Internal sample register, gap counter and width counter = 0.
- Sampling: TP is registered once (tp_q). A "new pulse" is the cycle in which tp_q is one-hot and differs from the previous tp_q. Detection latency: flags and CUR_T update 2 cycles after TP changes.
- ONEHOT_ERR:
  - Set whenever tp_q has ≥2 bits high, in any state.
  - The sample is not treated as a new pulse; state is unchanged.
- State IDLE:
  - Exit to TRACK on a new pulse equal to T01, provided GOJAM=0.
  - On that transition, CUR_T=1; MCT_COUNT not incremented.
  - All other pulses are ignored.
- State TRACK:
  - Expected index = CUR_T+1, wrapping 12→1.
  - New pulse == expected: CUR_T updates. If the transition is 12→1, MCT_COUNT increments (wraps at 2^CNT_W).
  - New pulse != expected: SEQ_ERR set. ERR_EXP/ERR_GOT are captured only if SEQ_ERR was previously 0. State → IDLE, CUR_T → 0.
  - GOJAM=1: state → IDLE, CUR_T → 0. No error. MCT_COUNT retained.
- Gap counter:
  - Increments each cycle tp_q==0 while TRACK and STOP=0.
  - Cleared on any nonzero tp_q.
  - Held, not cleared, while STOP=1.
  - On reaching GAP_MAX+1: GAP_ERR set, state → IDLE.
- STOP=1 does not freeze sequence checking; pulses arriving during STOP are still checked.
- CLR (sync, 1 cycle):
  - Clears all sticky flags, ERR_EXP, ERR_GOT and MCT_COUNT.
  - Does not change state or CUR_T.
  - CLR coincident with an error event: the error wins (flag set that cycle).
- Simultaneous events: GOJAM has priority over sequence check. Sequence check has priority over gap timeout.
- SIM_RST mid-operation: immediate return to reset values; no partial capture.

Optional Feature:
- Macro: TPULSE_WIDTH_CHK_EN.
- Defined:
  - Width counter counts cycles the current one-hot tp_q is held.
  - When it ends (tp_q changes), WIDTH_ERR is set if the width is < WMIN or > WMAX.
  - Checked in TRACK only. Suspended while STOP=1 or GOJAM=1.
- Undefined: WIDTH_ERR tied 0; no width counter logic.

Test Plan:
- Clean ring: GOJAM pulse, then 3 full T01..T12 cycles, each pulse 24 cycles wide → SYNCED=1; MCT_COUNT=2 (3rd wrap not yet seen); all error flags 0.
- Skip: in TRACK after T05, drive T07 → SEQ_ERR=1, ERR_EXP=6, ERR_GOT=7, SYNCED=0. A later T01 resyncs; SEQ_ERR stays 1 until CLR.
- Overlap: T03 and T04 high together for 5 cycles → ONEHOT_ERR=1; CUR_T stays 3; T04 alone then accepted, no SEQ_ERR.
- Stall: TP=0 for 65 cycles with STOP=0 → GAP_ERR=1, SYNCED=0. Repeat with STOP=1 for 200 cycles → GAP_ERR stays 0.
- GOJAM mid-ring: at T08 assert GOJAM → SYNCED=0, no errors, MCT_COUNT unchanged. Resumes counting after the next T01.
- With TPULSE_WIDTH_CHK_EN: T02 held 4 cycles → WIDTH_ERR=1. Without the macro, same stimulus → WIDTH_ERR=0.

Source files
------------

// File: rtl/tpulse_seq_monitor_if.sv
// Signal bundle between the a2_timer timepulse ring and its checker.
// Clock and reset stay as plain ports on the monitor.
interface tpulse_seq_monitor_if #(
    parameter int CNT_W = 16
);
    logic [11:0]      TP;
    logic             GOJAM;
    logic             STOP;
    logic             CLR;
    logic             SYNCED;
    logic [3:0]       CUR_T;
    logic [CNT_W-1:0] MCT_COUNT;
    logic             SEQ_ERR;
    logic             ONEHOT_ERR;
    logic             GAP_ERR;
    logic             WIDTH_ERR;
    logic [3:0]       ERR_EXP;
    logic [3:0]       ERR_GOT;
    logic             dbg_state;

    // There is no valid/ready handshake here: TP/GOJAM/STOP/CLR are levels
    // sampled on every SIM_CLK rising edge, and every status output is a
    // registered level that is meaningful on every cycle.
    modport master (
        output TP, GOJAM, STOP, CLR,
        input  SYNCED, CUR_T, MCT_COUNT, SEQ_ERR, ONEHOT_ERR, GAP_ERR,
        input  WIDTH_ERR, ERR_EXP, ERR_GOT, dbg_state
    );

    modport slave (
        input  TP, GOJAM, STOP, CLR,
        output SYNCED, CUR_T, MCT_COUNT, SEQ_ERR, ONEHOT_ERR, GAP_ERR,
        output WIDTH_ERR, ERR_EXP, ERR_GOT, dbg_state
    );
endinterface

// File: rtl/tpulse_seq_monitor.sv
// Receiver-side checker for the T01..T12 timepulse ring.
// Registers TP once, follows the expected T01..T12 order, counts completed
// MCTs (T12 -> T01) and raises sticky flags on skip, overlap and stall.
// Optional pulse-width checking is compiled in with TPULSE_WIDTH_CHK_EN.
module tpulse_seq_monitor #(
    parameter int CNT_W   = 16,
    parameter int GAP_MAX = 64
`ifdef TPULSE_WIDTH_CHK_EN
    ,
    parameter int WMIN    = 8,
    parameter int WMAX    = 40
`endif
) (
    input  logic                 SIM_CLK,
    input  logic                 SIM_RST,
    tpulse_seq_monitor_if.slave  mon
);
    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int GAP_W = $clog2(GAP_MAX + 2);

    state_t           state;
    state_t           state_nxt;
    logic [11:0]      tp_q;
    logic [11:0]      tp_prev;
    logic             tp_zero;
    logic             one_hot;
    logic             multi_hot;
    logic             new_pulse;
    logic [3:0]       tp_idx;
    logic [3:0]       exp_idx;
    logic             sync_gain;
    logic             seq_ok;
    logic             seq_bad;
    logic             gap_hit;
    logic [3:0]       cur_t;
    logic [3:0]       cur_t_nxt;
    logic             mct_inc;
    logic [CNT_W-1:0] mct;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_cnt_nxt;
    logic             seq_err;
    logic             onehot_err;
    logic             gap_err;
    logic             width_err;
    logic [3:0]       err_exp;
    logic [3:0]       err_got;

    // Single input register plus one cycle of history for edge detection.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            tp_q    <= '0;
            tp_prev <= '0;
        end else begin
            tp_q    <= mon.TP;
            tp_prev <= tp_q;
        end
    end

    // Decode the sampled ring: one-hot test, pulse index, expected successor.
    always_comb begin
        tp_zero   = (tp_q == 12'd0);
        multi_hot = ((tp_q & (tp_q - 12'd1)) != 12'd0);
        one_hot   = !tp_zero && !multi_hot;
        new_pulse = one_hot && (tp_q != tp_prev);
        tp_idx    = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (tp_q[i]) tp_idx = 4'(i + 1);
        end
        exp_idx = (cur_t == 4'd12) ? 4'd1 : cur_t + 4'd1;
    end

    // FSM state register.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) state <= IDLE;
        else         state <= state_nxt;
    end

    // FSM next state: GOJAM beats the sequence check, which beats the gap timeout.
    always_comb begin
        state_nxt = state;
        sync_gain = 1'b0;
        seq_ok    = 1'b0;
        seq_bad   = 1'b0;
        gap_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (new_pulse && (tp_idx == 4'd1) && !mon.GOJAM) begin
                    state_nxt = TRACK;
                    sync_gain = 1'b1;
                end
            end
            TRACK: begin
                if (mon.GOJAM) begin
                    state_nxt = IDLE;
                end else if (new_pulse) begin
                    if (tp_idx == exp_idx) begin
                        seq_ok = 1'b1;
                    end else begin
                        seq_bad   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tp_zero && !mon.STOP && (gap_cnt == GAP_W'(GAP_MAX))) begin
                    gap_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: next CUR_T, MCT increment and next gap count.
    always_comb begin
        cur_t_nxt = cur_t;
        mct_inc   = 1'b0;
        if (state_nxt == IDLE) begin
            cur_t_nxt = 4'd0;
        end else if (sync_gain) begin
            cur_t_nxt = 4'd1;
        end else if (seq_ok) begin
            cur_t_nxt = tp_idx;
            mct_inc   = (cur_t == 4'd12);
        end

        // Stall timer only runs while tracking; STOP freezes it in place.
        if (!tp_zero || (state != TRACK) || mon.GOJAM) begin
            gap_cnt_nxt = '0;
        end else if (!mon.STOP) begin
            gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end else begin
            gap_cnt_nxt = gap_cnt;
        end
    end

    // Status registers; an error event in the same cycle as CLR still sets its flag.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            cur_t      <= 4'd0;
            gap_cnt    <= '0;
            mct        <= '0;
            seq_err    <= 1'b0;
            onehot_err <= 1'b0;
            gap_err    <= 1'b0;
            err_exp    <= 4'd0;
            err_got    <= 4'd0;
        end else begin
            cur_t   <= cur_t_nxt;
            gap_cnt <= gap_cnt_nxt;
            if (mon.CLR)      mct <= '0;
            else if (mct_inc) mct <= mct + CNT_W'(1);
            if (mon.CLR) begin
                seq_err    <= 1'b0;
                onehot_err <= 1'b0;
                gap_err    <= 1'b0;
                err_exp    <= 4'd0;
                err_got    <= 4'd0;
            end
            if (multi_hot) onehot_err <= 1'b1;
            if (seq_bad) begin
                seq_err <= 1'b1;
                // Only the first skip since the last clear is recorded.
                if (!seq_err || mon.CLR) begin
                    err_exp <= exp_idx;
                    err_got <= tp_idx;
                end
            end
            if (gap_hit) gap_err <= 1'b1;
        end
    end

`ifdef TPULSE_WIDTH_CHK_EN
    localparam int WID_W = $clog2(WMAX + 2);

    logic [WID_W-1:0] wid_cnt;
    logic             wid_hit;

    // A pulse ends when tp_q changes; wid_cnt then holds the ended pulse's width.
    always_comb begin
        wid_hit = (state == TRACK) && !mon.STOP && !mon.GOJAM &&
                  (tp_q != tp_prev) && (wid_cnt != '0) &&
                  ((wid_cnt < WID_W'(WMIN)) || (wid_cnt > WID_W'(WMAX)));
    end

    // Width counter saturates just above WMAX, which is enough to flag "too long".
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            wid_cnt   <= '0;
            width_err <= 1'b0;
        end else begin
            if (!one_hot)                        wid_cnt <= '0;
            else if (tp_q != tp_prev)            wid_cnt <= WID_W'(1);
            else if (wid_cnt != WID_W'(WMAX + 1)) wid_cnt <= wid_cnt + WID_W'(1);
            if (mon.CLR) width_err <= 1'b0;
            if (wid_hit) width_err <= 1'b1;
        end
    end
`else
    assign width_err = 1'b0;
`endif

    assign mon.SYNCED     = (state == TRACK);
    assign mon.dbg_state  = (state == TRACK);
    assign mon.CUR_T      = cur_t;
    assign mon.MCT_COUNT  = mct;
    assign mon.SEQ_ERR    = seq_err;
    assign mon.ONEHOT_ERR = onehot_err;
    assign mon.GAP_ERR    = gap_err;
    assign mon.WIDTH_ERR  = width_err;
    assign mon.ERR_EXP    = err_exp;
    assign mon.ERR_GOT    = err_got;
endmodule

// File: tb/tb_tpulse_seq_monitor.sv
// Bench for tpulse_seq_monitor: directed ring scenarios plus random rings,
// with a per-cycle expected-output queue fed by a behavioural ring model.
module tb_tpulse_seq_monitor;
  localparam int CNT_W   = 16;
  localparam int GAP_MAX = 64;
`ifdef TPULSE_WIDTH_CHK_EN
  localparam int WMIN    = 8;
  localparam int WMAX    = 40;
`endif
  localparam int W = 1 + 4 + CNT_W + 4 + 4 + 4;

  // ---------------- clock / reset ----------------
  logic SIM_CLK = 1'b0;
  logic SIM_RST = 1'b1;

  always #5 SIM_CLK = ~SIM_CLK;

  tpulse_seq_monitor_if #(.CNT_W(CNT_W)) bus ();

  tpulse_seq_monitor #(.CNT_W(CNT_W), .GAP_MAX(GAP_MAX)) dut (
    .SIM_CLK (SIM_CLK),
    .SIM_RST (SIM_RST),
    .mon     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  bit          m_track;
  int          m_cur, m_mct, m_gap, m_exp, m_got;
  bit          m_seq, m_oh, m_gap_e, m_wid_e;
  logic [11:0] h1, h2;   // TP as seen one and two cycles back
`ifdef TPULSE_WIDTH_CHK_EN
  int          m_wid;
`endif

  function automatic void model_reset();
    m_track = 0; m_cur = 0; m_mct = 0; m_gap = 0; m_exp = 0; m_got = 0;
    m_seq = 0; m_oh = 0; m_gap_e = 0; m_wid_e = 0; h1 = '0; h2 = '0;
`ifdef TPULSE_WIDTH_CHK_EN
    m_wid = 0;
`endif
  endfunction

  // One clock edge: the ring is seen one cycle late, GOJAM/STOP/CLR are not.
  function automatic void model_step(input logic [11:0] tp, input bit gj, input bit st, input bit clr);
    logic [11:0] q, p;
    int bits, idx, nxt, e_exp, e_got;
    bit newp, was_track, seq_hit, gap_hit, prior_seq;
`ifdef TPULSE_WIDTH_CHK_EN
    bit wid_hit;
`endif
    q = h1; p = h2; h2 = h1; h1 = tp;
    bits = $countones(q);
    idx = 0;
    for (int i = 0; i < 12; i++) if (q[i]) idx = i + 1;
    newp = (bits == 1) && (q != p);
    was_track = m_track;
    seq_hit = 0; gap_hit = 0; e_exp = 0; e_got = 0;
`ifdef TPULSE_WIDTH_CHK_EN
    wid_hit = was_track && !st && !gj && (q != p) && (m_wid > 0) && ((m_wid < WMIN) || (m_wid > WMAX));
    m_wid = (bits == 1) ? ((q != p) ? 1 : m_wid + 1) : 0;
`endif
    if (was_track) begin
      if (gj) begin
        m_track = 0; m_cur = 0;
      end else if (newp) begin
        nxt = (m_cur % 12) + 1;
        if (idx == nxt) begin
          if (m_cur == 12) m_mct = (m_mct + 1) % (1 << CNT_W);
          m_cur = idx;
        end else begin
          seq_hit = 1; e_exp = nxt; e_got = idx; m_track = 0; m_cur = 0;
        end
      end else if ((q == 0) && !st) begin
        m_gap++;
        if (m_gap > GAP_MAX) begin
          gap_hit = 1; m_track = 0; m_cur = 0;
        end
      end
    end else if (newp && (idx == 1) && !gj) begin
      m_track = 1; m_cur = 1;
    end
    if ((q != 0) || !was_track || gj) m_gap = 0;

    prior_seq = m_seq;
    if (clr) begin
      m_seq = 0; m_oh = 0; m_gap_e = 0; m_wid_e = 0; m_exp = 0; m_got = 0; m_mct = 0;
    end
    if (bits >= 2) m_oh = 1;
    if (seq_hit) begin
      if (!prior_seq || clr) begin m_exp = e_exp; m_got = e_got; end
      m_seq = 1;
    end
    if (gap_hit) m_gap_e = 1;
`ifdef TPULSE_WIDTH_CHK_EN
    if (wid_hit) m_wid_e = 1;
`endif
  endfunction

  function automatic logic [W-1:0] model_out();
    return {m_track, 4'(m_cur), CNT_W'(m_mct), m_seq, m_oh, m_gap_e, m_wid_e, 4'(m_exp), 4'(m_got)};
  endfunction

  function automatic logic [W-1:0] dut_out();
    return {bus.SYNCED, bus.CUR_T, bus.MCT_COUNT, bus.SEQ_ERR, bus.ONEHOT_ERR,
            bus.GAP_ERR, bus.WIDTH_ERR, bus.ERR_EXP, bus.ERR_GOT};
  endfunction

  function automatic logic [11:0] tpv(input int k);
    return 12'd1 << (k - 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [11:0] tp, input bit gj = 1'b0, input bit st = 1'b0, input bit clr = 1'b0);
    @(negedge SIM_CLK);
    bus.TP = tp; bus.GOJAM = gj; bus.STOP = st; bus.CLR = clr;
    model_step(tp, gj, st, clr);
    exp_q.push_back(model_out());
  endtask

  task automatic hold(input logic [11:0] tp, input int n, input bit st = 1'b0);
    repeat (n) cyc(tp, 1'b0, st, 1'b0);
  endtask

  task automatic ring(input int from, input int to, input int w);
    for (int k = from; k <= to; k++) hold(tpv(k), w);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge SIM_CLK);
    SIM_RST = 1'b1;
    bus.TP = '0; bus.GOJAM = 0; bus.STOP = 0; bus.CLR = 0;
    model_reset();
    repeat (2) @(negedge SIM_CLK);
    chk("reset_outputs", 64'(dut_out()), 64'd0);
    SIM_RST = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    forever begin
      @(posedge SIM_CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = dut_out();
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got %h expected %h", $time, g, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r, w, k;
    logic [11:0] v;
    bit st;
    bus.TP = '0; bus.GOJAM = 0; bus.STOP = 0; bus.CLR = 0;
    model_reset();
    repeat (3) @(negedge SIM_CLK);
    chk("reset_outputs", 64'(dut_out()), 64'd0);
    SIM_RST = 1'b0;

    // Clean ring: two T12->T01 wraps over three rings.
    cyc('0, 1'b1);
    repeat (3) ring(1, 12, 24);
    chk("clean_synced", bus.SYNCED, 1);
    chk("clean_mct", bus.MCT_COUNT, 2);
    chk("clean_errs", {bus.SEQ_ERR, bus.ONEHOT_ERR, bus.GAP_ERR, bus.WIDTH_ERR}, 0);

    // Skip T06 after T05.
    for (int i = 1; i <= 5; i++) hold(tpv(i), $urandom_range(8, 40));
    hold(tpv(7), 10);
    chk("skip_seq", bus.SEQ_ERR, 1);
    chk("skip_exp", bus.ERR_EXP, 6);
    chk("skip_got", bus.ERR_GOT, 7);
    chk("skip_synced", bus.SYNCED, 0);
    chk("skip_cur", bus.CUR_T, 0);
    hold(tpv(1), 10);
    chk("resync_synced", bus.SYNCED, 1);
    chk("resync_seq_sticky", bus.SEQ_ERR, 1);
    cyc(tpv(1), 1'b0, 1'b0, 1'b1);
    hold(tpv(1), 3);
    chk("clr_seq", bus.SEQ_ERR, 0);
    chk("clr_mct", bus.MCT_COUNT, 0);
    chk("clr_keeps_cur", bus.CUR_T, 1);

    // Overlap T03+T04, then clean T04.
    ring(2, 3, 20);
    hold(tpv(3) | tpv(4), 5);
    chk("overlap_flag", bus.ONEHOT_ERR, 1);
    chk("overlap_cur", bus.CUR_T, 3);
    hold(tpv(4), 20);
    chk("overlap_accept_cur", bus.CUR_T, 4);
    chk("overlap_no_seq", bus.SEQ_ERR, 0);

    // Gap of exactly GAP_MAX is tolerated; GAP_MAX+1 is not.
    hold(tpv(5), 20);
    hold('0, GAP_MAX);
    hold(tpv(6), 20);
    chk("gap_edge_ok", bus.GAP_ERR, 0);
    chk("gap_edge_cur", bus.CUR_T, 6);
    hold('0, GAP_MAX + 1);
    hold('0, 3);
    chk("stall_gap", bus.GAP_ERR, 1);
    chk("stall_synced", bus.SYNCED, 0);
    cyc('0, 1'b0, 1'b0, 1'b1);
    hold(tpv(1), 20);
    hold('0, 200, 1'b1);
    chk("stop_no_gap", bus.GAP_ERR, 0);
    chk("stop_synced", bus.SYNCED, 1);

    // GOJAM at T08 after one wrap.
    ring(2, 12, 20);
    ring(1, 8, 20);
    cyc(tpv(8), 1'b1);
    hold(tpv(8), 3);
    chk("gojam_synced", bus.SYNCED, 0);
    chk("gojam_mct", bus.MCT_COUNT, 1);
    chk("gojam_errs", {bus.SEQ_ERR, bus.ONEHOT_ERR, bus.GAP_ERR}, 0);
    ring(9, 12, 20);
    ring(1, 12, 20);
    hold(tpv(1), 20);
    chk("gojam_resume_mct", bus.MCT_COUNT, 2);

    // Short T02.
    hold(tpv(2), 4);
    hold(tpv(3), 20);
`ifdef TPULSE_WIDTH_CHK_EN
    chk("short_width", bus.WIDTH_ERR, 1);
`else
    chk("short_width", bus.WIDTH_ERR, 0);
`endif

    do_reset();

    // Random rings with occasional skips, overlaps, gaps, GOJAM, STOP and CLR.
    cyc('0, 1'b1);
    k = 12;
    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 99);
      w = $urandom_range(1, 45);
      k = (k % 12) + 1;
      if (r < 8) k = $urandom_range(1, 12);
      v = tpv(k);
      if ((r >= 8) && (r < 13)) v = v | tpv($urandom_range(1, 12));
      st = ($urandom_range(0, 99) < 10);
      if ((r >= 13) && (r < 18)) hold('0, $urandom_range(1, 80), st);
      for (int c = 0; c < w; c++)
        cyc(v, $urandom_range(0, 199) == 0, st, $urandom_range(0, 299) == 0);
    end

    repeat (3) @(negedge SIM_CLK);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
